sdf_butterfly_4: RTL and testbench
==================================

SDF_BUTTERFLY_4 -- requirements
Module: sdf_butterfly_4

Interface
REQ-001 SHALL have parameter DW, default 24, meaning the signed word width of each real/imag component.
REQ-002 SHALL have parameter FRAC, default 8, meaning the number of fractional bits (1.0 = 0x000100).
REQ-003 SHALL have parameter DEPTH, default 4, meaning the number of complex samples in the feedback delay line.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  din_r/din_i carry a valid sample this cycle.
REQ-007 din_r, din_i  input  DW each  signed input sample, real and imaginary parts.
REQ-008 state  input  2  stage phase from the twiddle ROM: 0 = fill, 1 = butterfly, 2 = twiddle, 3 = reserved.
REQ-009 w_r, w_i  input  DW each  signed twiddle factor, valid in the same cycle as state.
REQ-010 out_valid  output  1  dout_r/dout_i hold a valid result.
REQ-011 dout_r, dout_i  output  DW each  signed result, registered.

Function
REQ-012 active = in_valid OR (state != 0); the delay line SHALL shift only when active = 1, and SHALL hold otherwise.
REQ-013 din SHALL be treated as 0 when in_valid = 0 and active = 1.
REQ-014 head = the oldest delay-line entry.
REQ-015 state 0, or state 3 (handled as 0): the delay line SHALL push din; out_valid SHALL go to 0 on the next edge.
REQ-016 state 1: the block SHALL register dout = head + din and push (head − din) into the delay line.
REQ-017 state 2: the block SHALL register dout = head × w and push din into the delay line.
REQ-018 The state 2 multiply SHALL be a full-precision complex multiply: real = w_r·h_r − w_i·h_i, imag = w_r·h_i + w_i·h_r, each arithmetic-shifted right by FRAC, truncated to the low DW bits.
REQ-019 Additions and subtractions SHALL wrap in two's complement at DW bits, with no saturation and no rounding.
REQ-020 Latency SHALL be 1 cycle: a result computed in cycle n SHALL appear on dout at edge n+1, with out_valid = 1 when active AND state ∈ {1,2} in cycle n.
REQ-021 When active = 0, out_valid SHALL go to 0 and dout SHALL hold its last value.
REQ-022 A state change between consecutive cycles SHALL take effect immediately, with no bubble.
REQ-023 The delay line SHALL be a pure FIFO of exactly DEPTH entries; each push discards the oldest entry.

Reset
REQ-024 On reset at a clock edge, all delay-line entries, dout_r, dout_i and out_valid SHALL become 0.
REQ-025 Reset SHALL take priority over active in the same cycle.
REQ-026 Reset mid-operation SHALL discard any partially formed group.

Structure
REQ-027 DW, FRAC, DEPTH and the state encodings (ST_FILL = 0, ST_BF = 1, ST_TW = 2) SHALL live in the shared FFT package.
REQ-028 The complex multiply SHALL be a combinational sub-module, cmplx_mult, reusable by the other stages.
REQ-029 The delay line SHALL be implemented inline as registers, not as a macro.

Verification
REQ-030 Reset: hold reset high for 2 cycles with arbitrary inputs → out_valid = 0, dout = 0, delay line = 0.
REQ-031 Fill and butterfly:
- state 0 for 4 cycles, din_r = 0x000100 (din_i = 0).
- then state 1 for 4 cycles, din_r = 0x000080.
- Response: 4 outputs dout_r = 0x000180 (dout_i = 0), each 1 cycle after its input.
- Response: delay line then holds 4 × 0x000080.
REQ-032 Twiddle, 45°:
- head = 0x000100 + j0, state 2, w = (0x0000B5, 0xFFFF4B).
- Response: dout_r = 0x0000B5, dout_i = 0xFFFF4B.
REQ-033 Twiddle, −j:
- head = 0x000100 + j0x000200, w = (0x000000, 0xFFFF00).
- Response: dout_r = 0x000200, dout_i = 0xFFFF00.
REQ-034 Wrap: head_r = 0x7FFFFF, din_r = 0x000001 in state 1 → dout_r = 0x800000, pushed difference = 0x7FFFFE.
REQ-035 Mid-operation reset and idle hold:
- Assert reset during state 1 → next edge: out_valid = 0, delay line = 0.
- state 0 with in_valid = 0 → delay line unchanged.

Source files
------------

// File: rtl/sdf_butterfly_4_pkg.sv
// Shared FFT package: default word format, delay depth and the stage-phase
// encoding driven by the twiddle ROM.
package sdf_butterfly_4_pkg;

    localparam int DW    = 24;  // signed width of each real/imag component
    localparam int FRAC  = 8;   // fractional bits, 1.0 = 1 << FRAC
    localparam int DEPTH = 4;   // complex samples held in the feedback delay line

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_BF   = 2'd1,
        ST_TW   = 2'd2,
        ST_RSV  = 2'd3
    } state_e;

endpackage

// File: rtl/sdf_butterfly_4_cmplx_mult.sv
// Combinational full-precision complex multiply p = a * b.
// Each component is computed at 2*DW+1 bits, arithmetic-shifted right by
// FRAC and truncated to the low DW bits (no rounding, no saturation).
// Ports:
//   a_r, a_i : first operand (signed, DW bits each)
//   b_r, b_i : second operand (signed, DW bits each)
//   p_r, p_i : scaled product (signed, DW bits each)
module cmplx_mult #(
    parameter int DW   = sdf_butterfly_4_pkg::DW,
    parameter int FRAC = sdf_butterfly_4_pkg::FRAC
) (
    input  logic signed [DW-1:0] a_r,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_r,
    input  logic signed [DW-1:0] b_i,
    output logic signed [DW-1:0] p_r,
    output logic signed [DW-1:0] p_i
);

    localparam int W2 = 2 * DW + 1;

    function automatic logic signed [DW-1:0] scale_trunc(input logic signed [W2-1:0] v);
        return DW'(v >>> FRAC);
    endfunction

    logic signed [W2-1:0] ar_x, ai_x, br_x, bi_x;
    logic signed [W2-1:0] sum_r, sum_i;

    // Sign-extend first so every product and sum is exact at W2 bits.
    assign ar_x = {{(DW+1){a_r[DW-1]}}, a_r};
    assign ai_x = {{(DW+1){a_i[DW-1]}}, a_i};
    assign br_x = {{(DW+1){b_r[DW-1]}}, b_r};
    assign bi_x = {{(DW+1){b_i[DW-1]}}, b_i};

    assign sum_r = ar_x * br_x - ai_x * bi_x;
    assign sum_i = ar_x * bi_x + ai_x * br_x;

    assign p_r = scale_trunc(sum_r);
    assign p_i = scale_trunc(sum_i);

endmodule

// File: rtl/sdf_butterfly_4.sv
// Single-path delay-feedback radix-2 butterfly stage with DEPTH-sample
// feedback delay line.
// Phases (from the twiddle ROM): fill pushes the input, butterfly outputs
// head + din and feeds back head - din, twiddle outputs head * w and pushes
// the input. The reserved phase behaves as fill.
// Ports:
//   clk            : clock, rising edge
//   reset          : synchronous active-high reset
//   in_valid       : din_r/din_i carry a sample this cycle
//   din_r, din_i   : signed input sample
//   state          : stage phase (0 fill, 1 butterfly, 2 twiddle, 3 = fill)
//   w_r, w_i       : signed twiddle factor for this cycle
//   out_valid      : dout_r/dout_i hold a fresh result
//   dout_r, dout_i : registered signed result
module sdf_butterfly_4
    import sdf_butterfly_4_pkg::*;
#(
    parameter int DW    = sdf_butterfly_4_pkg::DW,
    parameter int FRAC  = sdf_butterfly_4_pkg::FRAC,
    parameter int DEPTH = sdf_butterfly_4_pkg::DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] din_r,
    input  logic signed [DW-1:0] din_i,
    input  logic [1:0]           state,
    input  logic signed [DW-1:0] w_r,
    input  logic signed [DW-1:0] w_i,
    output logic                 out_valid,
    output logic signed [DW-1:0] dout_r,
    output logic signed [DW-1:0] dout_i
);

    logic signed [DW-1:0] dl_r [DEPTH];
    logic signed [DW-1:0] dl_i [DEPTH];

    state_e               st;
    logic                 active;
    logic                 produce;
    logic signed [DW-1:0] x_r, x_i;
    logic signed [DW-1:0] head_r, head_i;
    logic signed [DW-1:0] res_r, res_i;
    logic signed [DW-1:0] push_r, push_i;
    logic signed [DW-1:0] mul_r, mul_i;

    assign st     = state_e'(state);
    assign active = in_valid | (state != 2'd0);
    assign head_r = dl_r[DEPTH-1];
    assign head_i = dl_i[DEPTH-1];

    cmplx_mult #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_mult (
        .a_r (head_r),
        .a_i (head_i),
        .b_r (w_r),
        .b_i (w_i),
        .p_r (mul_r),
        .p_i (mul_i)
    );

    // Stage 0: combinational phase datapath
    always_comb begin
        // Gaps in the input stream still clock the line, carrying zeros.
        x_r     = in_valid ? din_r : '0;
        x_i     = in_valid ? din_i : '0;
        res_r   = '0;
        res_i   = '0;
        push_r  = x_r;
        push_i  = x_i;
        produce = 1'b0;
        case (st)
            ST_BF: begin
                res_r   = head_r + x_r;
                res_i   = head_i + x_i;
                push_r  = head_r - x_r;
                push_i  = head_i - x_i;
                produce = active;
            end
            ST_TW: begin
                res_r   = mul_r;
                res_i   = mul_i;
                produce = active;
            end
            default: ;
        endcase
    end

    // Stage 1: output register and delay line
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else begin
            out_valid <= produce;
            if (produce) begin
                dout_r <= res_r;
                dout_i <= res_i;
            end
            if (active) begin
                dl_r[0] <= push_r;
                dl_i[0] <= push_i;
                for (int k = 1; k < DEPTH; k++) begin
                    dl_r[k] <= dl_r[k-1];
                    dl_i[k] <= dl_i[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdf_butterfly_4.sv
module tb_sdf_butterfly_4;

    localparam int DW = 24;

    typedef struct {
        logic          v;
        logic [1:0]    st;
        logic [DW-1:0] dr, di, wr, wi;
        logic          ev;
        logic [DW-1:0] er, ei;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic signed [DW-1:0] din_r, din_i, w_r, w_i;
    logic [1:0]           state;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r, dout_i;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    sdf_butterfly_4 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .state     (state),
        .w_r       (w_r),
        .w_i       (w_i),
        .out_valid (out_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [1:0] st, input logic [DW-1:0] dr, di, wr, wi,
                       input logic ev, input logic [DW-1:0] er, ei);
        vec_t t;
        t.v = v; t.st = st; t.dr = dr; t.di = di; t.wr = wr; t.wi = wi;
        t.ev = ev; t.er = er; t.ei = ei;
        tbl.push_back(t);
    endtask

    // Apply one cycle of inputs and settle just after the rising edge.
    task automatic step(input logic v, input logic [1:0] st, input logic [DW-1:0] dr, di, wr, wi);
        in_valid = v; state = st; din_r = dr; din_i = di; w_r = wr; w_i = wi;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic ev, input logic [DW-1:0] er, ei);
        chk({name, ".vld"}, {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, ev});
        chk({name, ".r"}, dout_r, er);
        chk({name, ".i"}, dout_i, ei);
    endtask

    // Non-destructive read of the delay line: butterfly with a zero input
    // outputs head and feeds head back.
    task automatic read_line(input string name, input logic [DW-1:0] e0, e1, e2, e3);
        logic [DW-1:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 2'd1, 24'h00abcd, 24'h001234, 24'h0, 24'h0);
            expect_out($sformatf("%s[%0d]", name, k), 1'b1, e[k], 24'h0);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b1; state = 2'd1; din_r = 24'h123456; din_i = 24'h654321;
        w_r = 24'h000100; w_i = 24'h000077;

        // Reset with busy-looking inputs for two cycles.
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_out("reset", 1'b0, 24'h0, 24'h0);
        reset = 1'b0;
        read_line("reset_line", 24'h0, 24'h0, 24'h0, 24'h0);

        // Fill then butterfly with 1.0 and 0.5.
        for (int k = 0; k < 4; k++) add(1, 0, 24'h000100, 0, 0, 0, 0, 24'h0, 24'h0);
        for (int k = 0; k < 4; k++) add(1, 1, 24'h000080, 0, 0, 0, 1, 24'h000180, 24'h0);
        // Read back differences; din ignored while in_valid is low.
        for (int k = 0; k < 4; k++) add(0, 1, 24'h001234, 0, 0, 0, 1, 24'h000080, 24'h0);
        // Idle: out_valid drops, dout holds.
        add(0, 0, 24'h000999, 0, 0, 0, 0, 24'h000080, 24'h0);
        // Twiddle by 45 degrees on head = 1.0.
        for (int k = 0; k < 4; k++) add(1, 0, 24'h000100, 0, 0, 0, 0, 24'h000080, 24'h0);
        add(1, 2, 0, 0, 24'h0000b5, 24'hffff4b, 1, 24'h0000b5, 24'hffff4b);
        // Twiddle by -j on head = 1 + 2j.
        for (int k = 0; k < 4; k++) add(1, 0, 24'h000100, 24'h000200, 0, 0, 0, 24'h0000b5, 24'hffff4b);
        add(1, 2, 0, 0, 24'h000000, 24'hffff00, 1, 24'h000200, 24'hffff00);
        // Wrap: reserved phase acts as fill.
        for (int k = 0; k < 3; k++) add(1, 0, 24'h7fffff, 0, 0, 0, 0, 24'h000200, 24'hffff00);
        add(1, 3, 24'h7fffff, 0, 0, 0, 0, 24'h000200, 24'hffff00);
        add(1, 1, 24'h000001, 0, 0, 0, 1, 24'h800000, 24'h0);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 0, 1, 24'h7fffff, 24'h0);
        add(0, 1, 0, 0, 0, 0, 1, 24'h7ffffe, 24'h0);

        foreach (tbl[n]) begin
            step(tbl[n].v, tbl[n].st, tbl[n].dr, tbl[n].di, tbl[n].wr, tbl[n].wi);
            expect_out($sformatf("vec%0d", n), tbl[n].ev, tbl[n].er, tbl[n].ei);
        end

        // Reset in the middle of a butterfly group.
        for (int k = 0; k < 4; k++) step(1'b1, 2'd0, 24'h000055, 24'h0, 24'h0, 24'h0);
        step(1'b1, 2'd1, 24'h000001, 24'h0, 24'h0, 24'h0);
        expect_out("mid_bf", 1'b1, 24'h000056, 24'h0);
        reset = 1'b1;
        step(1'b1, 2'd1, 24'h000001, 24'h0, 24'h0, 24'h0);
        expect_out("mid_reset", 1'b0, 24'h0, 24'h0);
        reset = 1'b0;
        read_line("mid_line", 24'h0, 24'h0, 24'h0, 24'h0);

        // Idle hold: line frozen while inactive, order preserved.
        step(1'b1, 2'd0, 24'h000010, 24'h0, 24'h0, 24'h0);
        step(1'b1, 2'd0, 24'h000020, 24'h0, 24'h0, 24'h0);
        step(1'b1, 2'd0, 24'h000030, 24'h0, 24'h0, 24'h0);
        step(1'b1, 2'd0, 24'h000040, 24'h0, 24'h0, 24'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'd0, 24'h000999, 24'h000888, 24'h0, 24'h0);
            expect_out($sformatf("idle%0d", k), 1'b0, 24'h0, 24'h0);
        end
        read_line("idle_line", 24'h000010, 24'h000020, 24'h000030, 24'h000040);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
